// File: rtl/lsu_pkg.sv
// Shared types for the data-memory load/store unit.
// Misalignment trapping is enabled by defining LSU_MISALIGN_TRAP_EN.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DATA   = 2'b10,
    RESP   = 2'b11
  } state_e;

  localparam logic [3:0] LANE_NONE = 4'b0000;
  localparam logic [3:0] LANE_BYTE = 4'b0001;
  localparam logic [3:0] LANE_HALF = 4'b0011;
  localparam logic [3:0] LANE_WORD = 4'b1111;

  function automatic logic [3:0] lane_mask(size_e sz);
    logic [3:0] m;
    m = LANE_WORD;
    unique case (1'b1)
      sz == SZ_BYTE: m = LANE_BYTE;
      sz == SZ_HALF: m = LANE_HALF;
      default:       m = LANE_WORD;
    endcase
    return m;
  endfunction

  // Reserved size behaves as a word, so it shares the word alignment rule.
  function automatic logic misaligned(size_e sz, logic [1:0] lo);
    logic r;
    r = 1'b0;
    unique case (1'b1)
      sz == SZ_BYTE: r = 1'b0;
      sz == SZ_HALF: r = lo[0];
      default:       r = |lo;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Trims a 32-bit memory word to the access size and
// sign- or zero-extends it.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  size_e       size,
  input  logic        uns,
  output logic [31:0] data
);

  logic sb;
  logic sh;

  assign sb = ~uns & word[7];
  assign sh = ~uns & word[15];

  always_comb begin
    data = word;
    unique case (1'b1)
      size == SZ_BYTE: data = {{24{sb}}, word[7:0]};
      size == SZ_HALF: data = {{16{sh}}, word[15:0]};
      default:         data = word;
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Single-outstanding load/store unit in front of the banked data memory.
// Define LSU_MISALIGN_TRAP_EN to answer misaligned accesses with rsp_err.
module data_mem_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_raddress,
  output logic [ADDR_W-1:0] mem_waddress,
  output logic [DATA_W-1:0] mem_datain,
  output logic [3:0]        mem_wr,
  input  logic [DATA_W-1:0] mem_dataout
);

  state_e            state_q;
  state_e            state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              we_q;
  logic              uns_q;
  size_e             size_q;
  logic              err_q;
  logic              trap;
  logic              accept;
  logic [31:0]       ext;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = misaligned(size_e'(req_size), req_addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  assign accept = (state_q == IDLE) & req_valid;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_d = trap ? RESP : ACCESS;
      ACCESS:  state_d = we_q ? RESP : DATA;
      DATA:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Address/data only move on a real memory access so the
  // memory-facing buses keep their last value across traps.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept && !trap) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      we_q   <= 1'b0;
      uns_q  <= 1'b0;
      size_q <= SZ_BYTE;
      err_q  <= 1'b0;
    end else if (accept) begin
      we_q   <= req_we;
      uns_q  <= req_unsigned;
      size_q <= size_e'(req_size);
      err_q  <= trap;
    end
  end

  lsu_load_extend u_ext (
    .word (mem_dataout[31:0]),
    .size (size_q),
    .uns  (uns_q),
    .data (ext)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rdata_q <= '0;
    end else if (accept) begin
      rdata_q <= '0;
    end else if (state_q == DATA) begin
      rdata_q <= ext;
    end
  end

  assign req_ready    = (state_q == IDLE) & Reset_n;
  assign rsp_valid    = (state_q == RESP);
  assign rsp_rdata    = rdata_q;
  assign rsp_err      = err_q;
  assign mem_raddress = addr_q;
  assign mem_waddress = addr_q;
  assign mem_datain   = wdata_q;

  // Decoded from async-reset state so a reset kills the write at once.
  assign mem_wr = (state_q == ACCESS && we_q) ? lane_mask(size_q)
                                              : LANE_NONE;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed + random bench for data_mem_lsu with a byte-array
// memory and a byte-level reference model.
module tb_data_mem_lsu;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_raddress;
  logic [31:0] mem_waddress;
  logic [31:0] mem_datain;
  logic [3:0]  mem_wr;
  logic [31:0] mem_dataout = '0;

  logic [7:0] mem   [0:4095];
  logic [7:0] model [0:4095];

  int vectors = 0;
  int miscompares = 0;

  always #5 Clk = ~Clk;

  data_mem_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_raddress (mem_raddress),
    .mem_waddress (mem_waddress),
    .mem_datain   (mem_datain),
    .mem_wr       (mem_wr),
    .mem_dataout  (mem_dataout)
  );

  // Memory: lane i is the byte at address+i, one-cycle read latency.
  always @(posedge Clk) begin
    logic [31:0] rd;
    for (int i = 0; i < 4; i++)
      rd[8*i +: 8] = mem[12'(mem_raddress[11:0] + 12'(i))];
    mem_dataout <= rd;
    for (int i = 0; i < 4; i++)
      if (mem_wr[i])
        mem[12'(mem_waddress[11:0] + 12'(i))] = mem_datain[8*i +: 8];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic trap_of(input logic [1:0] size,
                                   input logic [31:0] addr);
`ifdef LSU_MISALIGN_TRAP_EN
    if (size == 2'd1) return addr[0];
    if (size >= 2'd2) return addr[1:0] != 2'b00;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size,
                                             input logic uns,
                                             input logic [11:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = model[12'(a + 12'(i))];
    case (size)
      2'd0: return uns ? 32'(w[7:0]) : 32'($signed(w[7:0]));
      2'd1: return uns ? 32'(w[15:0]) : 32'($signed(w[15:0]));
      default: return w;
    endcase
  endfunction

  // Called #1 after a rising edge with the unit idle.
  task automatic do_req(input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold);
    logic        tr;
    logic [3:0]  mask;
    logic [31:0] exp;
    int          nb;
    int          lat;
    int          k;
    tr   = trap_of(size, addr);
    nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    mask = (tr || !we) ? 4'b0000 : 4'((1 << nb) - 1);
    exp  = (we || tr) ? 32'h0 : model_load(size, uns, addr[11:0]);
    lat  = tr ? 0 : (we ? 1 : 2);
    if (we && !tr)
      for (int i = 0; i < nb; i++)
        model[12'(addr[11:0] + 12'(i))] = wdata[8*i +: 8];

    chk("req_ready_idle", 32'(req_ready), 32'h1);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    @(posedge Clk);
    #1;
    req_valid = 1'b0;
    req_wdata = $urandom;
    chk("mem_wr_access", 32'(mem_wr), 32'(mask));
    chk("req_ready_busy", 32'(req_ready), 32'h0);
    if (!tr) begin
      chk("mem_raddress", mem_raddress, addr);
      chk("mem_waddress", mem_waddress, addr);
      if (we) chk("mem_datain", mem_datain, wdata);
    end
    k = 0;
    while (!rsp_valid && k < 8) begin
      @(posedge Clk);
      #1;
      k++;
      chk("mem_wr_after", 32'(mem_wr), 32'h0);
    end
    chk("rsp_latency", 32'(k), 32'(lat));
    chk("rsp_valid", 32'(rsp_valid), 32'h1);
    chk("rsp_rdata", rsp_rdata, exp);
    chk("rsp_err", 32'(rsp_err), 32'(tr));
    for (int j = 0; j < hold; j++) begin
      req_valid = 1'b1;
      @(posedge Clk);
      #1;
      chk("hold_valid", 32'(rsp_valid), 32'h1);
      chk("hold_rdata", rsp_rdata, exp);
      chk("hold_err", 32'(rsp_err), 32'(tr));
      chk("hold_req_ready", 32'(req_ready), 32'h0);
    end
    // A request offered during the handshake edge must not be taken.
    req_valid = 1'b1;
    req_we    = 1'b0;
    rsp_ready = 1'b1;
    @(posedge Clk);
    #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk("rsp_valid_done", 32'(rsp_valid), 32'h0);
    chk("req_ready_back", 32'(req_ready), 32'h1);
  endtask

  initial begin
    logic [7:0] b;
    for (int i = 0; i < 4096; i++) begin
      b = 8'($urandom);
      mem[i]   = b;
      model[i] = b;
    end

    repeat (3) @(posedge Clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_mem_wr", 32'(mem_wr), 32'h0);
    chk("rst_mem_raddress", mem_raddress, 32'h0);
    chk("rst_mem_waddress", mem_waddress, 32'h0);
    chk("rst_mem_datain", mem_datain, 32'h0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;

    do_req(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0);
    chk("word_const", rsp_rdata, 32'hDEADBEEF);
    do_req(1'b1, 2'd0, 1'b0, 32'h103, 32'h00000080, 0);
    do_req(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 0);
    do_req(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 1);
    do_req(1'b1, 2'd1, 1'b0, 32'h200, 32'h00008001, 0);
    do_req(1'b0, 2'd1, 1'b1, 32'h200, 32'h0, 0);
    do_req(1'b0, 2'd1, 1'b0, 32'h200, 32'h0, 5);
    do_req(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 0);
    do_req(1'b0, 2'd1, 1'b0, 32'h201, 32'h0, 2);
    do_req(1'b1, 2'd3, 1'b0, 32'h203, 32'h12345678, 0);
    do_req(1'b0, 2'd3, 1'b1, 32'h204, 32'h0, 0);

    // Reset during the ACCESS cycle of a word store.
    do_req(1'b1, 2'd2, 1'b0, 32'h400, 32'h11223344, 0);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'd2;
    req_addr  = 32'h400;
    req_wdata = 32'hCAFEF00D;
    @(posedge Clk);
    #1;
    req_valid = 1'b0;
    chk("abort_mem_wr_pre", 32'(mem_wr), 32'hF);
    Reset_n = 1'b0;
    #1;
    chk("abort_mem_wr", 32'(mem_wr), 32'h0);
    chk("abort_req_ready", 32'(req_ready), 32'h0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("abort_mem_raddress", mem_raddress, 32'h0);
    chk("abort_mem_datain", mem_datain, 32'h0);
    @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    chk("abort_idle", 32'(req_ready), 32'h1);
    do_req(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 0);

    for (int n = 0; n < 40; n++) begin
      do_req(1'($urandom), 2'($urandom), 1'($urandom),
             32'h300 + 32'($urandom_range(0, 240)),
             $urandom, int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
